// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select encodings and arbiter FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first set request after ptr,
// wrapping modulo NREQ, so the last winner always ends up lowest priority.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  grant,
  output logic            any_req
);

  // Walk the candidates ptr+1 .. ptr+NREQ and keep the first one that is requesting.
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    logic           found;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    any_req = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external combinational ALU between NREQ requesters.
// Each operation is a fixed IDLE -> EXEC -> RESP walk: operands are
// registered on the grant, the ALU settles for one cycle, and the result
// is held on a single tagged response channel until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]  req_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_out
);

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [IDW-1:0] grant;
  logic           any_req;
  logic           grant_fire;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [1:0]       pick_sel;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  // A grant only happens from IDLE and never while reset is being applied.
  assign grant_fire = (state == ST_IDLE) && any_req && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state: EXEC is always exactly one cycle, RESP waits for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (any_req)   state_next = ST_EXEC;
      ST_EXEC:                state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Outputs: one-hot accept strobe for the winner during the grant cycle only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = grant_fire && (grant == IDW'(i));
    busy = (state != ST_IDLE);
  end

  // Select the winning requester's operands out of the packed input buses.
  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = ALU_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        pick_a   = req_a[i*WIDTH +: WIDTH];
        pick_b   = req_b[i*WIDTH +: WIDTH];
        pick_sel = req_sel[i*2 +: 2];
      end
    end
  end

  // Operand registers and fairness pointer; they only move on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= IDW'(NREQ-1);
      id      <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= ALU_ADD;
    end else if (grant_fire) begin
      ptr     <= grant;
      id      <= grant;
      alu_a   <= pick_a;
      alu_b   <= pick_b;
      alu_sel <= pick_sel;
    end
  end

  // Result register: capture the ALU after its settle cycle, drop valid on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (state == ST_EXEC) begin
        rsp_data  <= alu_out;
        rsp_id    <= id;
        rsp_valid <= 1'b1;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an external behavioural ALU.
// A transaction-level reference model runs alongside directed and random traffic.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [1:0]            alu_sel;
  logic [WIDTH-1:0]      alu_out;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add, subtract, and, or.
  function automatic logic [WIDTH-1:0] aluRef(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = aluRef(alu_a, alu_b, alu_sel);

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [1:0] op);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_sel[idx*2 +: 2]       = op;
    req_valid[idx]            = 1'b1;
  endtask

  // Reference model: an idle/busy arbiter that remembers the last winner and
  // the one operation in flight, expressed in terms of transactions.
  bit               modelOn = 1'b0;
  int               mLast;
  bit               mBusy, mExec, mResp;
  logic [WIDTH-1:0] mA, mB, mPend, mData;
  logic [1:0]       mSel;
  int               mPendId, mIdOut;
  int               mGrant;

  always @(negedge clk) begin : refModel
    logic [NREQ-1:0] expReady;
    expReady = '0;
    mGrant   = -1;
    if (!rst && !mBusy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (mLast + k) % NREQ;
        if (mGrant < 0 && req_valid[c]) mGrant = c;
      end
      if (mGrant >= 0) expReady[mGrant] = 1'b1;
    end
    if (modelOn) begin
      checkOutput("m_req_ready", WIDTH'(req_ready), WIDTH'(expReady));
      checkOutput("m_busy", WIDTH'(busy), WIDTH'(mBusy));
      checkOutput("m_rsp_valid", WIDTH'(rsp_valid), WIDTH'(mResp));
      checkOutput("m_rsp_data", rsp_data, mData);
      checkOutput("m_rsp_id", WIDTH'(rsp_id), WIDTH'(mIdOut));
      checkOutput("m_alu_a", alu_a, mA);
      checkOutput("m_alu_b", alu_b, mB);
      checkOutput("m_alu_sel", WIDTH'(alu_sel), WIDTH'(mSel));
    end
    if (rst) begin
      modelOn = 1'b1;
      mLast = NREQ-1; mBusy = 0; mExec = 0; mResp = 0;
      mA = '0; mB = '0; mSel = '0; mPend = '0; mData = '0;
      mPendId = 0; mIdOut = 0;
    end else if (modelOn) begin
      if (mGrant >= 0) begin
        mBusy   = 1'b1;
        mExec   = 1'b1;
        mLast   = mGrant;
        mA      = req_a[mGrant*WIDTH +: WIDTH];
        mB      = req_b[mGrant*WIDTH +: WIDTH];
        mSel    = req_sel[mGrant*2 +: 2];
        mPend   = aluRef(mA, mB, mSel);
        mPendId = mGrant;
      end else if (mExec) begin
        mExec  = 1'b0;
        mResp  = 1'b1;
        mData  = mPend;
        mIdOut = mPendId;
      end else if (mResp && rsp_ready) begin
        mResp = 1'b0;
        mBusy = 1'b0;
      end
    end
  end

  task automatic doReset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitResp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    if (!rsp_valid) checkOutput("resp_timeout", WIDTH'(rsp_valid), WIDTH'(1));
  endtask

  task automatic doOp(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input logic [WIDTH-1:0] expData, input string tag);
    int n;
    logic [NREQ-1:0] e;
    e = '0;
    e[idx] = 1'b1;
    applyStimulus(idx, a, b, op);
    @(negedge clk);
    checkOutput({tag, "_ready"}, WIDTH'(req_ready), WIDTH'(e));
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
    waitResp(n);
    checkOutput({tag, "_latency"}, WIDTH'(n), WIDTH'(2));
    checkOutput({tag, "_data"}, rsp_data, expData);
    checkOutput({tag, "_id"}, WIDTH'(rsp_id), WIDTH'(idx));
    @(posedge clk);
    #1;
  endtask

  function automatic int onehotIndex(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin : stim
    int n;
    int gIdx[$];
    int gCyc[$];
    int cyc;
    logic [WIDTH-1:0] holdData;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
    doReset();

    $display("[TB] single request and logic ops");
    doOp(0, 32'h0000_FFFF, 32'hFFFF_0000, ALU_ADD, 32'hFFFF_FFFF, "t1_add");
    doOp(2, 32'hFFFF_5828, 32'hFFFF_0828, ALU_SUB, 32'h0000_5000, "t2_sub");
    doOp(2, 32'h0A0A_0A0A, 32'h0000_FFFF, ALU_AND, 32'h0000_0A0A, "t2_and");

    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, $urandom, $urandom, 2'($urandom));
    cyc = 0;
    while (gIdx.size() < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        gIdx.push_back(onehotIndex(req_ready));
        gCyc.push_back(cyc);
      end
    end
    checkOutput("rr_count", WIDTH'(gIdx.size()), WIDTH'(5));
    for (int i = 0; i < gIdx.size(); i++) begin
      checkOutput("rr_order", WIDTH'(gIdx[i]), WIDTH'(i % NREQ));
      if (i > 0) checkOutput("rr_spacing", WIDTH'(gCyc[i] - gCyc[i-1]), WIDTH'(3));
    end
    @(posedge clk);
    #1 req_valid = '0;
    waitResp(n);
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1, 32'h1234_5678, 32'h0000_1111, ALU_OR);
    @(negedge clk);
    checkOutput("bp_ready", WIDTH'(req_ready), WIDTH'(4'b0010));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    applyStimulus(3, 32'd7, 32'd9, ALU_ADD);
    waitResp(n);
    holdData = aluRef(32'h1234_5678, 32'h0000_1111, ALU_OR);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", WIDTH'(rsp_valid), WIDTH'(1));
      checkOutput("bp_data", rsp_data, holdData);
      checkOutput("bp_id", WIDTH'(rsp_id), WIDTH'(1));
      checkOutput("bp_noready", WIDTH'(req_ready), WIDTH'(0));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_next_grant", WIDTH'(req_ready), WIDTH'(4'b1000));
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    waitResp(n);
    checkOutput("bp_next_data", rsp_data, 32'd16);
    @(posedge clk);
    #1;

    $display("[TB] withdrawn request");
    applyStimulus(0, 32'd100, 32'd1, ALU_SUB);
    @(negedge clk);
    checkOutput("wd_ready", WIDTH'(req_ready), WIDTH'(4'b0001));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    applyStimulus(1, 32'd5, 32'd5, ALU_ADD);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("wd_rsp_id", WIDTH'(rsp_id), WIDTH'(0));
    checkOutput("wd_rsp_data", rsp_data, 32'd99);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wd_no_grant", WIDTH'(req_ready), WIDTH'(0));
      checkOutput("wd_no_rsp", WIDTH'(rsp_valid), WIDTH'(0));
    end
    @(posedge clk);
    #1;

    $display("[TB] reset mid-operation");
    applyStimulus(0, 32'hF0F0_F0F0, 32'h0, ALU_OR);
    @(negedge clk);
    checkOutput("rm_ready", WIDTH'(req_ready), WIDTH'(4'b0001));
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rm_busy_exec", WIDTH'(busy), WIDTH'(1));
    @(posedge clk);
    @(negedge clk);
    checkOutput("rm_rsp_valid", WIDTH'(rsp_valid), WIDTH'(0));
    checkOutput("rm_busy", WIDTH'(busy), WIDTH'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 32'd1, 32'd2, ALU_ADD);
    @(negedge clk);
    checkOutput("rm_first_grant", WIDTH'(req_ready), WIDTH'(4'b0001));
    @(posedge clk);
    #1 req_valid = '0;
    waitResp(n);
    checkOutput("rm_after_data", rsp_data, 32'd3);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*WIDTH +: WIDTH] = $urandom;
        req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? req_a[i*WIDTH +: WIDTH] : $urandom;
        req_sel[i*2 +: 2]       = 2'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 59) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
